// File: rtl/lpc_io_host.sv
// lpc_io_host
// LPC 1.1 host-side initiator for 8-bit I/O read and write cycles. It takes one
// request at a time from an internal master, runs the complete LPC cycle on
// LFRAME#/LAD, and returns a single-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while idle. rsp_valid is a one-cycle pulse with no
// backpressure, and rsp_rdata/rsp_error are meaningful only while it is high.
//
// Ports
//   lpc_clock, lpc_reset      clock; synchronous active-high reset
//   req_valid/ready/write     request handshake and direction (1 = I/O write)
//   req_addr[15:0]            I/O address
//   req_wdata[7:0]            write data
//   rsp_valid/rdata/error     completion pulse, read data, error flag
//   lpc_ad_in[3:0]            sampled LAD
//   lpc_ad_out[3:0]           driven LAD
//   lpc_ad_oe                 1 = host drives LAD
//   lpc_frame                 LFRAME#, active low
//   dbg_state[3:0]            current FSM state, for observation
module lpc_io_host #(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LWAIT_TIMEOUT = 256
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame,
  output logic [3:0]  dbg_state
);

  // One counter serves both as the nibble index in multi-cycle phases and as
  // the SYNC wait counter, so it must hold the long-wait limit.
  localparam int CW = $clog2(LWAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] SY_LIM = CW'(SYNC_TIMEOUT);
  localparam logic [CW-1:0] LW_LIM = CW'(LWAIT_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR_H, S_SYNC,
    S_RDATA, S_TAR_P, S_ABORT, S_ABORT_REL, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          lwait_q, lwait_d;

  logic          frame_q, frame_d;
  logic          oe_q, oe_d;
  logic [3:0]    ad_q, ad_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;

  logic [CW-1:0] sync_next;
  logic          long_wait;
  logic [CW-1:0] sync_limit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    lwait_d    = lwait_q;
    sync_next  = cnt_q + CW'(1);
    long_wait  = lwait_q | (lpc_ad_in == 4'b0110);
    sync_limit = long_wait ? LW_LIM : SY_LIM;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 8'h00;
          err_d   = 1'b0;
          lwait_d = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START:   state_d = S_CYCTYPE;
      S_CYCTYPE: begin
        state_d = S_ADDR;
        cnt_d   = '0;
      end
      S_ADDR: begin
        if (cnt_q == CW'(3)) begin
          state_d = write_q ? S_WDATA : S_TAR_H;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WDATA, S_TAR_H, S_TAR_P: begin
        if (cnt_q == CW'(1)) begin
          cnt_d = '0;
          case (state_q)
            S_WDATA: state_d = S_TAR_H;
            S_TAR_H: state_d = S_SYNC;
            default: state_d = S_RESP;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SYNC: begin
        if (lpc_ad_in == 4'b0000 || lpc_ad_in == 4'b1010) begin
          err_d   = (lpc_ad_in == 4'b1010);
          state_d = write_q ? S_TAR_P : S_RDATA;
          cnt_d   = '0;
        end else begin
          // Any non-terminal code is a wait; once 0110 has appeared the long
          // limit stays in force even if the peripheral reverts to 0101.
          lwait_d = long_wait;
          cnt_d   = sync_next;
          if (sync_next >= sync_limit) begin
            state_d = S_ABORT;
            cnt_d   = '0;
          end
        end
      end
      S_RDATA: begin
        if (cnt_q == CW'(0)) begin
          rdata_d[3:0] = lpc_ad_in;
          cnt_d        = CW'(1);
        end else begin
          rdata_d[7:4] = lpc_ad_in;
          cnt_d        = '0;
          state_d      = S_TAR_P;
        end
      end
      S_ABORT: begin
        err_d   = 1'b1;
        rdata_d = 8'h00;
        if (cnt_q == CW'(3)) begin
          state_d = S_ABORT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ABORT_REL: state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Bus and response outputs are registered, so they are derived from the
    // state being entered rather than the current one.
    frame_d     = 1'b1;
    oe_d        = 1'b0;
    ad_d        = 4'b1111;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'h00;
    rsp_error_d = 1'b0;
    case (state_d)
      S_IDLE:  req_ready_d = 1'b1;
      S_START: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
        ad_d    = 4'b0000;
      end
      S_CYCTYPE: begin
        oe_d = 1'b1;
        ad_d = write_d ? 4'b0010 : 4'b0000;
      end
      S_ADDR: begin
        oe_d = 1'b1;
        case (cnt_d[1:0])
          2'd0:    ad_d = addr_d[15:12];
          2'd1:    ad_d = addr_d[11:8];
          2'd2:    ad_d = addr_d[7:4];
          default: ad_d = addr_d[3:0];
        endcase
      end
      S_WDATA: begin
        oe_d = 1'b1;
        ad_d = cnt_d[0] ? wdata_d[7:4] : wdata_d[3:0];
      end
      // First turnaround cycle drives 1111, second releases the bus.
      S_TAR_H: oe_d = (cnt_d == '0);
      S_ABORT: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata_d;
        rsp_error_d = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      lwait_q     <= 1'b0;
      frame_q     <= 1'b1;
      oe_q        <= 1'b0;
      ad_q        <= 4'b1111;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      lwait_q     <= lwait_d;
      frame_q     <= frame_d;
      oe_q        <= oe_d;
      ad_q        <= ad_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;
  assign lpc_ad_out = ad_q;
  assign lpc_ad_oe  = oe_q;
  assign lpc_frame  = frame_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lpc_io_host.sv
// tb_lpc_io_host
// Directed and randomized LPC I/O cycles against lpc_io_host. A reference model
// builds, from the LPC cycle rules, the expected per-cycle bus picture
// (LFRAME#, output enable, LAD) together with the peripheral's LAD answers,
// and the expected response. The bench drives the peripheral side from that
// plan and checks every cycle.
module tb_lpc_io_host;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [3:0]  lpc_ad_in;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic        lpc_frame;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Per cycle of a transaction: {frame, oe, ad, peripheral drive}.
  logic [9:0]  exp_q[$];
  logic [3:0]  sync_q[$];

  lpc_io_host dut (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .lpc_ad_in (lpc_ad_in),
    .lpc_ad_out(lpc_ad_out),
    .lpc_ad_oe (lpc_ad_oe),
    .lpc_frame (lpc_frame),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 lpc_clock = ~lpc_clock;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cyc(input logic f, input logic o, input logic [3:0] a, input logic [3:0] d);
    exp_q.push_back({f, o, a, d});
  endtask

  // Reference model: the LPC I/O cycle laid out phase by phase.
  task automatic build_model(input logic w, input logic [15:0] a, input logic [7:0] wd,
                             input logic [7:0] rd, output logic [7:0] e_rdata,
                             output logic e_err);
    logic       lw;
    logic [3:0] code;
    bit         aborted;
    int         limit;
    exp_q.delete();
    lw = 1'b0;
    aborted = 1'b0;
    e_err = 1'b0;
    push_cyc(1'b0, 1'b1, 4'h0, 4'hF);
    push_cyc(1'b1, 1'b1, w ? 4'h2 : 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) push_cyc(1'b1, 1'b1, a[15-4*i -: 4], 4'hF);
    if (w) begin
      push_cyc(1'b1, 1'b1, wd[3:0], 4'hF);
      push_cyc(1'b1, 1'b1, wd[7:4], 4'hF);
    end
    push_cyc(1'b1, 1'b1, 4'hF, 4'hF);
    push_cyc(1'b1, 1'b0, 4'hF, 4'hF);
    for (int i = 0; i < 400; i++) begin
      code = (i < sync_q.size()) ? sync_q[i] : 4'hF;
      push_cyc(1'b1, 1'b0, 4'hF, code);
      if (code == 4'h0 || code == 4'hA) begin
        e_err = (code == 4'hA);
        break;
      end
      if (code == 4'h6) lw = 1'b1;
      limit = lw ? 256 : 8;
      if (i + 1 >= limit) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      for (int i = 0; i < 4; i++) push_cyc(1'b0, 1'b1, 4'hF, 4'hF);
      push_cyc(1'b1, 1'b0, 4'hF, 4'hF);
      e_err = 1'b1;
      e_rdata = 8'h00;
    end else begin
      if (!w) begin
        push_cyc(1'b1, 1'b0, 4'hF, rd[3:0]);
        push_cyc(1'b1, 1'b0, 4'hF, rd[7:4]);
      end
      push_cyc(1'b1, 1'b0, 4'hF, 4'hF);
      push_cyc(1'b1, 1'b0, 4'hF, 4'hF);
      e_rdata = w ? 8'h00 : rd;
    end
    push_cyc(1'b1, 1'b0, 4'hF, 4'hF);
  endtask

  // Driver: one complete transaction. exp_lat > 0 also checks the observed
  // accept-to-response distance against that fixed figure.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input bit keep_valid, input int exp_lat);
    logic [7:0]  e_rdata;
    logic        e_err;
    logic [9:0]  e;
    logic [15:0] dec_addr;
    logic [7:0]  dec_data;
    int          len;
    int          rsp_cyc;
    build_model(w, a, wd, rd, e_rdata, e_err);
    len = exp_q.size();
    rsp_cyc = -1;
    dec_addr = 16'h0;
    dec_data = 8'h0;
    @(negedge lpc_clock);
    chk("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    for (int c = 1; c <= len; c++) begin
      @(posedge lpc_clock);
      #1;
      e = exp_q[c-1];
      lpc_ad_in = e[3:0];
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      req_write = 1'($urandom);
      if (!keep_valid || c == len) req_valid = 1'b0;
      @(negedge lpc_clock);
      chk("frame", lpc_frame, e[9]);
      chk("oe", lpc_ad_oe, e[8]);
      if (e[8]) chk("lad", lpc_ad_out, e[7:4]);
      chk("ready_busy", req_ready, 1'b0);
      chk("rsp_valid", rsp_valid, c == len);
      if (rsp_valid && rsp_cyc < 0) rsp_cyc = c;
      if (c >= 3 && c <= 6 && lpc_ad_oe) dec_addr = {dec_addr[11:0], lpc_ad_out};
      if (w && c == 7) dec_data[3:0] = lpc_ad_out;
      if (w && c == 8) dec_data[7:4] = lpc_ad_out;
      if (c == len) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_error", rsp_error, e_err);
      end
    end
    chk("loopback_addr", dec_addr, a);
    if (w) chk("loopback_data", dec_data, wd);
    if (exp_lat > 0) chk("latency", 16'(rsp_cyc), 16'(exp_lat));
    @(posedge lpc_clock);
    #1;
    lpc_ad_in = 4'hF;
    @(negedge lpc_clock);
    chk("ready_after", req_ready, 1'b1);
    chk("rsp_after", rsp_valid, 1'b0);
    chk("frame_after", lpc_frame, 1'b1);
    chk("oe_after", lpc_ad_oe, 1'b0);
  endtask

  task automatic rand_sync();
    int n;
    int t;
    logic [3:0] codes [5];
    codes[0] = 4'h5; codes[1] = 4'h6; codes[2] = 4'hF; codes[3] = 4'h3; codes[4] = 4'hC;
    sync_q.delete();
    n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) sync_q.push_back(codes[$urandom_range(0, 4)]);
    t = $urandom_range(0, 4);
    if (t <= 1) sync_q.push_back(4'h0);
    else if (t == 2) sync_q.push_back(4'hA);
    else if (t == 3) sync_q.push_back(4'h5);
  endtask

  initial begin
    lpc_reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 8'h0;
    lpc_ad_in = 4'hF;
    repeat (3) @(posedge lpc_clock);
    #1;
    lpc_reset = 1'b0;
    @(negedge lpc_clock);
    chk("reset_frame", lpc_frame, 1'b1);
    chk("reset_oe", lpc_ad_oe, 1'b0);
    chk("reset_lad", lpc_ad_out, 4'hF);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rdata", rsp_rdata, 8'h00);
    chk("reset_error", rsp_error, 1'b0);

    // Write 0x0080 / 0xA5, immediate ready SYNC.
    sync_q = '{4'h0};
    run_txn(1'b1, 16'h0080, 8'hA5, 8'h00, 1'b0, 14);
    // Read 0x03F8 returning 0xC3.
    sync_q = '{4'h0};
    run_txn(1'b0, 16'h03F8, 8'h00, 8'hC3, 1'b0, 14);
    // Three short waits then ready.
    sync_q = '{4'h5, 4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'($urandom), 8'h00, 8'($urandom), 1'b0, 17);
    // No response at all: timeout abort.
    sync_q.delete();
    run_txn(1'b0, 16'h0060, 8'h00, 8'h5A, 1'b0, 0);
    run_txn(1'b1, 16'h0064, 8'h3C, 8'h00, 1'b0, 0);
    // Long wait for 100 cycles, then ready.
    sync_q.delete();
    for (int i = 0; i < 100; i++) sync_q.push_back(4'h6);
    sync_q.push_back(4'h0);
    run_txn(1'b0, 16'h1234, 8'h00, 8'h9E, 1'b0, 0);
    // Long wait held past the long limit: abort.
    sync_q.delete();
    for (int i = 0; i < 300; i++) sync_q.push_back(4'h6);
    run_txn(1'b1, 16'hBEEF, 8'h77, 8'h00, 1'b0, 0);
    // Long wait once, then short-wait codes beyond the short limit.
    sync_q.delete();
    sync_q.push_back(4'h6);
    for (int i = 0; i < 12; i++) sync_q.push_back(4'h5);
    sync_q.push_back(4'h0);
    run_txn(1'b0, 16'h2E8, 8'h00, 8'h41, 1'b1, 0);
    // Short wait right up to the short limit boundary.
    sync_q.delete();
    for (int i = 0; i < 7; i++) sync_q.push_back(4'h5);
    sync_q.push_back(4'h0);
    run_txn(1'b1, 16'h0378, 8'h81, 8'h00, 1'b0, 21);
    // Error SYNC on read (data still captured) and on write.
    sync_q = '{4'hA};
    run_txn(1'b0, 16'h0070, 8'h00, 8'hE4, 1'b0, 14);
    sync_q = '{4'h5, 4'hA};
    run_txn(1'b1, 16'h0071, 8'h19, 8'h00, 1'b0, 15);

    // Reset during the address phase.
    @(negedge lpc_clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h4321;
    req_wdata = 8'h66;
    for (int c = 1; c <= 4; c++) begin
      @(posedge lpc_clock);
      #1;
      req_valid = 1'b0;
    end
    lpc_reset = 1'b1;
    @(posedge lpc_clock);
    #1;
    lpc_reset = 1'b0;
    @(negedge lpc_clock);
    chk("midreset_frame", lpc_frame, 1'b1);
    chk("midreset_oe", lpc_ad_oe, 1'b0);
    chk("midreset_ready", req_ready, 1'b1);
    chk("midreset_rsp", rsp_valid, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge lpc_clock);
      chk("midreset_quiet", {rsp_valid, lpc_frame, lpc_ad_oe}, 3'b010);
    end

    // Randomized back-to-back traffic.
    for (int k = 0; k < 20; k++) begin
      rand_sync();
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
